// File: rtl/encoder_pkg.sv
// Shared types, opcodes and immediate-range helpers for the RV32I instruction encoder.
package encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BEAT_FIRST = 2'd1,
    ST_BEAT_LAST  = 2'd2
  } state_e;

  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_OPIMM = 7'b0010011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // 12-bit signed: everything above bit 11 is a copy of bit 11.
  function automatic logic imm_fits_i(input logic [31:0] imm);
    return imm[31:11] == {21{imm[11]}};
  endfunction

  function automatic logic imm_fits_s(input logic [31:0] imm);
    return imm_fits_i(imm);
  endfunction

  // 13-bit signed, halfword aligned.
  function automatic logic imm_fits_b(input logic [31:0] imm);
    return (imm[0] == 1'b0) && (imm[31:12] == {20{imm[12]}});
  endfunction

  // Upper 20 bits only; the low 12 bits cannot be expressed.
  function automatic logic imm_fits_u(input logic [31:0] imm);
    return imm[11:0] == 12'h000;
  endfunction

  // 21-bit signed, halfword aligned.
  function automatic logic imm_fits_j(input logic [31:0] imm);
    return (imm[0] == 1'b0) && (imm[31:20] == {12{imm[20]}});
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters fields and the immediate into one RV32I word and
// reports whether the immediate is representable. Unrepresentable -> NOP.
module imm_pack
  import encoder_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  // Per-format bit scatter and legality; illegal or unknown formats collapse to NOP.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    instr_o = NOP;
    legal_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = imm_fits_i(imm_i);
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = imm_fits_s(imm_i);
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        legal_o = imm_fits_b(imm_i);
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        legal_o = imm_fits_u(imm_i);
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal_o = imm_fits_j(imm_i);
      end
      default: begin
        instr_o = NOP;
        legal_o = 1'b0;
      end
    endcase
    if (!legal_o) instr_o = NOP;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI pseudo-op expansion and a registered
// valid/ready output stream (one beat per cycle, one cycle request-to-beat).
module instr_encoder
  import encoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_fmt_i,
  input  logic [6:0]  req_opcode_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [6:0]  req_funct7_i,
  input  logic [31:0] req_imm_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_last_o,
  output logic        err_o
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;

  fmt_e        req_fmt;
  logic        accept;
  logic        li_fits12;
  logic        li_two;
  logic [19:0] li_upper;

  fmt_e        pk_fmt;
  logic [6:0]  pk_op;
  logic [4:0]  pk_rd;
  logic [4:0]  pk_rs1;
  logic [2:0]  pk_f3;
  logic [31:0] pk_imm;
  logic [31:0] pk_word;
  logic        pk_legal;

  assign req_fmt     = fmt_e'(req_fmt_i);
  assign req_ready_o = (state_q == ST_IDLE) | ((state_q == ST_BEAT_LAST) & instr_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  // (imm + 0x800)[31:12]: the +0x800 only carries into bit 12 when bit 11 is set,
  // which pre-compensates for the sign-extended ADDI that follows. Wraps mod 2^32.
  assign li_fits12 = imm_fits_i(req_imm_i);
  assign li_upper  = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
  assign li_two    = (req_fmt == FMT_LI) & ~li_fits12 & (req_imm_i[11:0] != 12'h000);

  // Select what the shared packer encodes: the second LI beat from held copies,
  // otherwise the incoming request (LI rewritten to ADDI or LUI).
  always_comb begin
    pk_fmt = req_fmt;
    pk_op  = req_opcode_i;
    pk_rd  = req_rd_i;
    pk_rs1 = req_rs1_i;
    pk_f3  = req_funct3_i;
    pk_imm = req_imm_i;
    if (state_q == ST_BEAT_FIRST) begin
      pk_fmt = FMT_I;
      pk_op  = OP_OPIMM;
      pk_rd  = rd_q;
      pk_rs1 = rd_q;
      pk_f3  = 3'b000;
      pk_imm = {{20{lo_q[11]}}, lo_q};
    end else if (req_fmt == FMT_LI) begin
      pk_f3 = 3'b000;
      if (li_fits12) begin
        pk_fmt = FMT_I;
        pk_op  = OP_OPIMM;
        pk_rs1 = 5'd0;
      end else begin
        pk_fmt = FMT_U;
        pk_op  = OP_LUI;
        pk_imm = {li_upper, 12'h000};
      end
    end
  end

  imm_pack u_imm_pack (
    .fmt_i    (pk_fmt),
    .opcode_i (pk_op),
    .rd_i     (pk_rd),
    .rs1_i    (pk_rs1),
    .rs2_i    (req_rs2_i),
    .funct3_i (pk_f3),
    .funct7_i (req_funct7_i),
    .imm_i    (pk_imm),
    .instr_o  (pk_word),
    .legal_o  (pk_legal)
  );

  // Next-state and next-output-register logic for the beat FSM.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    rd_d    = rd_q;
    lo_d    = lo_q;
    if (accept) begin
      instr_d = pk_word;
      err_d   = ~pk_legal;
      last_d  = ~li_two;
      rd_d    = req_rd_i;
      lo_d    = req_imm_i[11:0];
      state_d = li_two ? ST_BEAT_FIRST : ST_BEAT_LAST;
    end else begin
      case (state_q)
        ST_BEAT_FIRST: begin
          if (instr_ready_i) begin
            instr_d = pk_word;
            err_d   = 1'b0;
            last_d  = 1'b1;
            state_d = ST_BEAT_LAST;
          end
        end
        ST_BEAT_LAST: begin
          if (instr_ready_i) state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Control state and the visible output register, cleared by reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      instr_q <= 32'h0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Request holding copies for the second LI beat.
  always_ff @(posedge clk_i) begin
    // NOTE: these datapath copies are deliberately unreset; they are only read after an accept loads them.
    rd_q <= rd_d;
    lo_q <= lo_d;
  end

  assign instr_valid_o = (state_q != ST_IDLE);
  assign instr_o       = instr_q;
  assign instr_last_o  = last_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// backpressure/reset sequences, and a randomized sweep checked by decoding and
// executing the emitted words.
module tb_instr_encoder;
  import encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_fmt_i;
  logic [6:0]  req_opcode_i;
  logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
  logic [2:0]  req_funct3_i;
  logic [6:0]  req_funct7_i;
  logic [31:0] req_imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic        instr_last_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_fmt_i     (req_fmt_i),
    .req_opcode_i  (req_opcode_i),
    .req_rd_i      (req_rd_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_funct3_i  (req_funct3_i),
    .req_funct7_i  (req_funct7_i),
    .req_imm_i     (req_imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_last_o  (instr_last_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    int          nb;
    logic [31:0] w0;
    logic        l0;
    logic        e0;
    logic [31:0] w1;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] bw[$];
  logic        bl[$];
  logic        be[$];
  int          first_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic req_t mk(input fmt_e f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = f; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic vec_t mkv(input req_t r, input int nb, input logic [31:0] w0,
                               input logic l0, input logic e0, input logic [31:0] w1);
    vec_t v;
    v.r = r; v.nb = nb; v.w0 = w0; v.l0 = l0; v.e0 = e0; v.w1 = w1;
    return v;
  endfunction

  task automatic drive_req(input req_t r);
    req_fmt_i    = r.fmt;
    req_opcode_i = r.op;
    req_rd_i     = r.rd;
    req_rs1_i    = r.rs1;
    req_rs2_i    = r.rs2;
    req_funct3_i = r.f3;
    req_funct7_i = r.f7;
    req_imm_i    = r.imm;
  endtask

  // Issue one request from idle and collect every handshaken beat. first_lat counts
  // samples after the accepting edge until the first valid beat (0 = next cycle).
  task automatic run_req(input req_t r, input bit rand_rdy);
    int n;
    bit done;
    bit prev_stall;
    logic [34:0] prev;
    bw.delete(); bl.delete(); be.delete();
    first_lat = -1;
    @(negedge clk);
    drive_req(r);
    req_valid_i   = 1'b1;
    instr_ready_i = 1'b1;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("accept");
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0; done = 1'b0; prev_stall = 1'b0; prev = '0;
    while (!done && n < 60) begin
      if (prev_stall)
        check("hold_stable", {instr_valid_o, instr_last_o, err_o, instr_o}, prev);
      if (rand_rdy) instr_ready_i = ($urandom_range(3) != 0);
      if (instr_valid_o === 1'b1) begin
        if (first_lat < 0) first_lat = n;
        if (instr_ready_i) begin
          bw.push_back(instr_o);
          bl.push_back(instr_last_o);
          be.push_back(err_o);
          if (instr_last_o) done = 1'b1;
        end
      end
      prev_stall = (instr_valid_o === 1'b1) && !instr_ready_i;
      prev = {instr_valid_o, instr_last_o, err_o, instr_o};
      @(negedge clk);
      n++;
    end
    if (!done) timeout("beats");
    instr_ready_i = 1'b1;
  endtask

  // Immediate generator (decode direction).
  function automatic logic [31:0] dec_imm(input fmt_e f, input logic [31:0] w);
    case (f)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'h000};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Representability from plain signed ranges.
  function automatic bit legal_ref(input fmt_e f, input logic [31:0] imm);
    longint s;
    s = $signed(imm);
    case (f)
      FMT_R:        return 1'b1;
      FMT_I, FMT_S: return (s >= -2048) && (s <= 2047);
      FMT_B:        return (imm[0] == 1'b0) && (s >= -4096) && (s <= 4094);
      FMT_U:        return (imm % 4096) == 0;
      FMT_J:        return (imm[0] == 1'b0) && (s >= -1048576) && (s <= 1048574);
      default:      return 1'b0;
    endcase
  endfunction

  task automatic check_random(input req_t r);
    fmt_e f;
    longint s;
    int exp_nb;
    logic [31:0] xr[32];
    logic [31:0] w;
    f = fmt_e'(r.fmt);
    s = $signed(r.imm);
    if (f == FMT_LI) begin
      exp_nb = ((s >= -2048 && s <= 2047) || r.imm[11:0] == 12'h000) ? 1 : 2;
      check("li_nbeats", bw.size(), exp_nb);
      for (int i = 0; i < 32; i++) xr[i] = 32'hDEAD_BEEF;
      xr[0] = 32'h0;
      foreach (bw[i]) begin
        w = bw[i];
        check("li_beat_flags", {bl[i], be[i], w[11:7]}, {(i == bw.size() - 1), 1'b0, r.rd});
        if (w[6:0] == OP_LUI)
          xr[w[11:7]] = {w[31:12], 12'h000};
        else if (w[6:0] == OP_OPIMM && w[14:12] == 3'b000)
          xr[w[11:7]] = xr[w[19:15]] + {{20{w[31]}}, w[31:20]};
        else
          check("li_opcode", w[6:0], OP_OPIMM);
      end
      check("li_value", xr[r.rd], r.imm);
    end else begin
      check("rnd_nbeats", bw.size(), 1);
      if (bw.size() == 1) begin
        w = bw[0];
        if (!legal_ref(f, r.imm)) begin
          check("rnd_illegal", {bl[0], be[0], w}, {1'b1, 1'b1, NOP});
        end else begin
          check("rnd_flags", {bl[0], be[0], w[6:0]}, {1'b1, 1'b0, r.op});
          case (f)
            FMT_R:        check("rnd_r_word", w, {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op});
            FMT_I:        check("rnd_i_regs", {w[19:15], w[14:12], w[11:7]}, {r.rs1, r.f3, r.rd});
            FMT_S, FMT_B: check("rnd_sb_regs", {w[24:20], w[19:15], w[14:12]}, {r.rs2, r.rs1, r.f3});
            default:      check("rnd_uj_rd", w[11:7], r.rd);
          endcase
          if (f != FMT_R) check("rnd_imm_roundtrip", dec_imm(f, w), r.imm);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_t r;
    rst_ni = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b0;
    drive_req(mk(FMT_R, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {instr_valid_o, instr_last_o, err_o, instr_o}, 35'd0);
    rst_ni = 1'b1;
    check("reset_ready", req_ready_o, 1'b1);

    // Directed vectors.
    vecs.push_back(mkv(mk(FMT_I, 7'h13, 5'd5, 5'd6, 5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF), 1, 32'hFFF30293, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC), 1, 32'hFE208EE3, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3), 1, 32'h00000013, 1, 1, 0));
    vecs.push_back(mkv(mk(FMT_LI, 7'h7F, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF), 2, 32'h12346537, 0, 0, 32'hFFF50513));
    vecs.push_back(mkv(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1, 32'h00500513, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hFFFF_FFFF), 1, 32'h403100B3, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_S, 7'h23, 5'd7, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8), 1, 32'h00512423, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_U, 7'h37, 5'd1, 5'd3, 5'd0, 3'd7, 7'd0, 32'h12345000), 1, 32'h123450B7, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001), 1, 32'h00000013, 1, 1, 0));
    vecs.push_back(mkv(mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800), 1, 32'h001000EF, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000), 1, 32'h8000006F, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000), 1, 32'h00000013, 1, 1, 0));
    vecs.push_back(mkv(mk(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF), 1, 32'h7FF00013, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800), 1, 32'h00000013, 1, 1, 0));
    vecs.push_back(mkv(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000), 1, 32'h80208063, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00001000), 1, 32'h00000013, 1, 1, 0));
    vecs.push_back(mkv(mk(FMT_LI, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800), 1, 32'h80000193, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_LI, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000), 1, 32'hABCDE0B7, 1, 0, 0));
    vecs.push_back(mkv(mk(FMT_LI, 7'h00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFFFFFF), 2, 32'h80000137, 0, 0, 32'hFFF10113));

    foreach (vecs[i]) begin
      run_req(vecs[i].r, 1'b0);
      check($sformatf("v%0d_latency", i), first_lat, 0);
      check($sformatf("v%0d_nbeats", i), bw.size(), vecs[i].nb);
      if (bw.size() >= 1)
        check($sformatf("v%0d_beat0", i), {bl[0], be[0], bw[0]}, {vecs[i].l0, vecs[i].e0, vecs[i].w0});
      if (vecs[i].nb == 2 && bw.size() == 2)
        check($sformatf("v%0d_beat1", i), {bl[1], be[1], bw[1]}, {1'b1, 1'b0, vecs[i].w1});
    end

    // Backpressure during LI beat 1, then a back-to-back request as beat 2 retires.
    @(negedge clk);
    drive_req(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF));
    req_valid_i = 1'b1; instr_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_beat1_hold", {instr_valid_o, instr_last_o, instr_o}, {1'b1, 1'b0, 32'h12346537});
      check("bp_ready_low", req_ready_o, 1'b0);
      @(negedge clk);
    end
    instr_ready_i = 1'b1;
    @(negedge clk);
    check("bp_beat2", {instr_valid_o, instr_last_o, err_o, instr_o}, {1'b1, 1'b1, 1'b0, 32'hFFF50513});
    drive_req(mk(FMT_I, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF));
    req_valid_i = 1'b1;
    check("bp_ready_same_cycle", req_ready_o, 1'b1);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("bp_no_bubble", {instr_valid_o, instr_last_o, err_o, instr_o}, {1'b1, 1'b1, 1'b0, 32'hFFF30293});
    @(negedge clk);
    check("bp_drained", instr_valid_o, 1'b0);

    // Reset after the LI beat 1 handshake drops beat 2.
    drive_req(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF));
    req_valid_i = 1'b1; instr_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rst_seq_beat1", {instr_valid_o, instr_o}, {1'b1, 32'h12346537});
    @(negedge clk);
    instr_ready_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    check("rst_seq_cleared", {instr_valid_o, instr_last_o, err_o, instr_o}, 35'd0);
    rst_ni = 1'b1;
    check("rst_seq_ready", req_ready_o, 1'b1);
    instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_seq_no_beat2", instr_valid_o, 1'b0);
    end

    // Randomized sweep with random sink backpressure.
    for (int it = 0; it < 400; it++) begin
      int mode;
      int v;
      r.fmt = 3'($urandom_range(6));
      r.op  = 7'($urandom); r.rd  = 5'($urandom); r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom); r.f3  = 3'($urandom); r.f7  = 7'($urandom);
      mode = $urandom_range(4);
      case (mode)
        0: r.imm = $urandom;
        1: begin v = int'($urandom_range(4095)) - 2048;       r.imm = v; end
        2: begin v = (int'($urandom_range(8191)) - 4096) & ~1; r.imm = v; end
        3: begin v = (int'($urandom_range(2097151)) - 1048576) & ~1; r.imm = v; end
        default: r.imm = $urandom & 32'hFFFF_F000;
      endcase
      run_req(r, 1'b1);
      check("rnd_latency", first_lat, 0);
      check_random(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
